// File: rtl/img_bbox_detect.sv
// -----------------------------------------------------------------------------
// img_bbox_detect
//
// Colour-threshold bounding-box detector placed directly in front of the
// rectangle-overlay stage. Each active pixel is foreground when all three
// 8-bit channels lie inside an inclusive [thr_lo, thr_hi] window. The min/max
// column and row of foreground pixels are tracked over a frame and published
// on the rising edge of vertical sync. Video is passed through with a single
// register stage so it stays aligned with the overlay input.
//
// Stream semantics: the video stream has no backpressure. A pixel is
// transferred on every clock where de_i is high; there is no ready signal and
// the block never stalls.
//
// Ports
//   clk          pixel clock
//   rst_n        asynchronous active-low reset
//   vs_i         vertical sync, active-high, level clears the row counter
//   hs_i         horizontal sync, active-high, level clears the column counter
//   de_i         active-pixel qualifier
//   data_i       pixel {R[23:16], G[15:8], B[7:0]}
//   thr_lo       per-channel inclusive lower bound (same packing)
//   thr_hi       per-channel inclusive upper bound (same packing)
//   vs_o/hs_o/de_o/data_o   inputs delayed by one cycle, unmodified
//   rect_x1/y1   last published min column / min row
//   rect_x2/y2   last published max column / max row
//   rect_valid   last published box had at least MIN_PIX foreground pixels
//   frame_done   one-cycle pulse when the box outputs update
//   dbg_state_o  current FSM state (0 = IDLE, 1 = ACTIVE)
// -----------------------------------------------------------------------------
module img_bbox_detect #(
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 480,
    parameter int MIN_PIX = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vs_i,
    input  logic        hs_i,
    input  logic        de_i,
    input  logic [23:0] data_i,
    input  logic [23:0] thr_lo,
    input  logic [23:0] thr_hi,
    output logic        vs_o,
    output logic        hs_o,
    output logic        de_o,
    output logic [23:0] data_o,
    output logic [10:0] rect_x1,
    output logic [10:0] rect_y1,
    output logic [10:0] rect_x2,
    output logic [10:0] rect_y2,
    output logic        rect_valid,
    output logic        frame_done,
    output logic        dbg_state_o
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    // 12-bit limits so an 11-bit counter compares cleanly against IMG_W/IMG_H.
    localparam logic [11:0] COL_LIM  = 12'(IMG_W);
    localparam logic [11:0] ROW_LIM  = 12'(IMG_H);
    localparam logic [10:0] COL_LAST = 11'(IMG_W - 1);
    localparam logic [20:0] FG_MIN   = 21'(MIN_PIX);
    localparam logic [10:0] MIN_INIT = 11'h7FF;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_e      state_q, state_d;
    logic        vs_d_q;

    logic        vs_q, hs_q, de_q;
    logic [23:0] data_q;

    logic [10:0] col_cnt_q, col_cnt_d;
    logic [10:0] row_cnt_q, row_cnt_d;

    logic [10:0] min_x_q, min_x_d;
    logic [10:0] min_y_q, min_y_d;
    logic [10:0] max_x_q, max_x_d;
    logic [10:0] max_y_q, max_y_d;
    logic [20:0] fg_cnt_q, fg_cnt_d;

    logic [10:0] rect_x1_q, rect_x1_d;
    logic [10:0] rect_y1_q, rect_y1_d;
    logic [10:0] rect_x2_q, rect_x2_d;
    logic [10:0] rect_y2_q, rect_y2_d;
    logic        rect_valid_q, rect_valid_d;
    logic        frame_done_q, frame_done_d;

    // ------------------------------------------------------------------
    // Classification
    // ------------------------------------------------------------------
    function automatic logic in_win(input logic [7:0] v,
                                    input logic [7:0] lo,
                                    input logic [7:0] hi);
        // lo > hi makes the window empty without any special casing.
        return (v >= lo) && (v <= hi);
    endfunction

    logic colour_hit;
    logic fg;
    logic vs_rise;

    assign colour_hit = in_win(data_i[23:16], thr_lo[23:16], thr_hi[23:16]) &&
                        in_win(data_i[15:8],  thr_lo[15:8],  thr_hi[15:8])  &&
                        in_win(data_i[7:0],   thr_lo[7:0],   thr_hi[7:0]);

    // !vs_i keeps a pixel coincident with the sync edge out of the frame
    // being published on that same edge.
    assign fg = de_i && !vs_i &&
                ({1'b0, col_cnt_q} < COL_LIM) &&
                ({1'b0, row_cnt_q} < ROW_LIM) &&
                colour_hit;

    assign vs_rise = vs_i && !vs_d_q;

    // ------------------------------------------------------------------
    // Position counters
    // ------------------------------------------------------------------
    always_comb begin
        col_cnt_d = col_cnt_q;
        row_cnt_d = row_cnt_q;
        if (hs_i) begin
            col_cnt_d = 11'd0;
        end else if (de_i) begin
            col_cnt_d = col_cnt_q + 11'd1;
        end
        if (vs_i) begin
            row_cnt_d = 11'd0;
        end else if (de_i && (col_cnt_q == COL_LAST)) begin
            row_cnt_d = row_cnt_q + 11'd1;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and control strobes
    // ------------------------------------------------------------------
    logic publish;
    logic acc_init;

    always_comb begin
        state_d  = state_q;
        publish  = 1'b0;
        acc_init = 1'b0;
        case (state_q)
            IDLE: begin
                // Accumulators stay at init; the first sync only arms, so a
                // partial frame after reset is never reported.
                acc_init = 1'b1;
                if (vs_rise) begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (vs_rise) begin
                    publish  = 1'b1;
                    acc_init = 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                acc_init = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Accumulators
    // ------------------------------------------------------------------
    always_comb begin
        min_x_d  = min_x_q;
        min_y_d  = min_y_q;
        max_x_d  = max_x_q;
        max_y_d  = max_y_q;
        fg_cnt_d = fg_cnt_q;
        if (acc_init) begin
            min_x_d  = MIN_INIT;
            min_y_d  = MIN_INIT;
            max_x_d  = 11'd0;
            max_y_d  = 11'd0;
            fg_cnt_d = 21'd0;
        end else if (fg) begin
            if (col_cnt_q < min_x_q) min_x_d = col_cnt_q;
            if (row_cnt_q < min_y_q) min_y_d = row_cnt_q;
            if (col_cnt_q > max_x_q) max_x_d = col_cnt_q;
            if (row_cnt_q > max_y_q) max_y_d = row_cnt_q;
            if (fg_cnt_q != '1) fg_cnt_d = fg_cnt_q + 21'd1;
        end
    end

    // ------------------------------------------------------------------
    // Publish
    // ------------------------------------------------------------------
    always_comb begin
        rect_x1_d    = rect_x1_q;
        rect_y1_d    = rect_y1_q;
        rect_x2_d    = rect_x2_q;
        rect_y2_d    = rect_y2_q;
        rect_valid_d = rect_valid_q;
        frame_done_d = 1'b0;
        if (publish) begin
            frame_done_d = 1'b1;
            if (fg_cnt_q >= FG_MIN) begin
                rect_x1_d    = min_x_q;
                rect_y1_d    = min_y_q;
                rect_x2_d    = max_x_q;
                rect_y2_d    = max_y_q;
                rect_valid_d = 1'b1;
            end else begin
                // Too few pixels: keep the old box so the overlay does not
                // jump, but flag it as stale.
                rect_valid_d = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequential
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            vs_d_q       <= 1'b0;
            vs_q         <= 1'b0;
            hs_q         <= 1'b0;
            de_q         <= 1'b0;
            data_q       <= 24'd0;
            col_cnt_q    <= 11'd0;
            row_cnt_q    <= 11'd0;
            min_x_q      <= MIN_INIT;
            min_y_q      <= MIN_INIT;
            max_x_q      <= 11'd0;
            max_y_q      <= 11'd0;
            fg_cnt_q     <= 21'd0;
            rect_x1_q    <= 11'd0;
            rect_y1_q    <= 11'd0;
            rect_x2_q    <= 11'd0;
            rect_y2_q    <= 11'd0;
            rect_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            vs_d_q       <= vs_i;
            vs_q         <= vs_i;
            hs_q         <= hs_i;
            de_q         <= de_i;
            data_q       <= data_i;
            col_cnt_q    <= col_cnt_d;
            row_cnt_q    <= row_cnt_d;
            min_x_q      <= min_x_d;
            min_y_q      <= min_y_d;
            max_x_q      <= max_x_d;
            max_y_q      <= max_y_d;
            fg_cnt_q     <= fg_cnt_d;
            rect_x1_q    <= rect_x1_d;
            rect_y1_q    <= rect_y1_d;
            rect_x2_q    <= rect_x2_d;
            rect_y2_q    <= rect_y2_d;
            rect_valid_q <= rect_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign vs_o        = vs_q;
    assign hs_o        = hs_q;
    assign de_o        = de_q;
    assign data_o      = data_q;
    assign rect_x1     = rect_x1_q;
    assign rect_y1     = rect_y1_q;
    assign rect_x2     = rect_x2_q;
    assign rect_y2     = rect_y2_q;
    assign rect_valid  = rect_valid_q;
    assign frame_done  = frame_done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_img_bbox_detect.sv
// -----------------------------------------------------------------------------
// tb_img_bbox_detect
//
// Directed bench for img_bbox_detect on a reduced 64x48 frame. Two instances
// share all inputs: dut0 uses MIN_PIX=16, dut1 uses MIN_PIX=1 so the single
// pixel and short-run frames can be checked for both outcomes at once.
// -----------------------------------------------------------------------------
module tb_img_bbox_detect;

    localparam int W = 64;
    localparam int H = 48;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        vs_i = 1'b0, hs_i = 1'b0, de_i = 1'b0;
    logic [23:0] data_i = 24'd0;
    logic [23:0] thr_lo = 24'hC00000;
    logic [23:0] thr_hi = 24'hFF3F3F;

    logic        vs_o0, hs_o0, de_o0, rv0, fd0, st0;
    logic [23:0] data_o0;
    logic [10:0] x1_0, y1_0, x2_0, y2_0;
    logic        vs_o1, hs_o1, de_o1, rv1, fd1, st1;
    logic [23:0] data_o1;
    logic [10:0] x1_1, y1_1, x2_1, y2_1;

    img_bbox_detect #(.IMG_W(W), .IMG_H(H), .MIN_PIX(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .vs_i(vs_i), .hs_i(hs_i), .de_i(de_i),
        .data_i(data_i), .thr_lo(thr_lo), .thr_hi(thr_hi),
        .vs_o(vs_o0), .hs_o(hs_o0), .de_o(de_o0), .data_o(data_o0),
        .rect_x1(x1_0), .rect_y1(y1_0), .rect_x2(x2_0), .rect_y2(y2_0),
        .rect_valid(rv0), .frame_done(fd0), .dbg_state_o(st0)
    );

    img_bbox_detect #(.IMG_W(W), .IMG_H(H), .MIN_PIX(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .vs_i(vs_i), .hs_i(hs_i), .de_i(de_i),
        .data_i(data_i), .thr_lo(thr_lo), .thr_hi(thr_hi),
        .vs_o(vs_o1), .hs_o(hs_o1), .de_o(de_o1), .data_o(data_o1),
        .rect_x1(x1_1), .rect_y1(y1_1), .rect_x2(x2_1), .rect_y2(y2_1),
        .rect_valid(rv1), .frame_done(fd1), .dbg_state_o(st1)
    );

    // ---------------- checking ----------------
    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // ---------------- pass-through scoreboard ----------------
    logic [26:0] exp_q[$];
    bit          pt_en = 1'b0;

    always @(posedge clk) begin
        if (pt_en) exp_q.push_back({vs_i, hs_i, de_i, data_i});
    end

    always @(negedge clk) begin
        if (pt_en && exp_q.size() > 0) begin
            logic [26:0] e;
            e = exp_q.pop_front();
            check("passthru0", {37'd0, vs_o0, hs_o0, de_o0, data_o0}, {37'd0, e});
            check("passthru1", {37'd0, vs_o1, hs_o1, de_o1, data_o1}, {37'd0, e});
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [23:0] pix(input int c, input int r,
                                        input int bx0, input int bx1,
                                        input int by0, input int by1,
                                        input bit extra);
        if (c < W && r < H && c >= bx0 && c <= bx1 && r >= by0 && r <= by1)
            return ((c + r) % 2 == 1) ? 24'hFF0000 : 24'hC03F3F;
        if (extra && (c == 70 || r == H)) return 24'hFF0000;
        case ((c + r) % 4)
            0: return 24'h000000;
            1: return 24'hBF0000;   // R one below lower bound
            2: return 24'hFF4000;   // G one above upper bound
            default: return 24'hFF0040; // B one above upper bound
        endcase
    endfunction

    // Drive nl lines; with extra, each line carries 7 pixels past IMG_W and
    // the caller adds a line beyond IMG_H.
    task automatic lines(input int bx0, input int bx1, input int by0, input int by1,
                         input bit extra, input int nl);
        for (int r = 0; r < nl; r++) begin
            repeat (4) begin
                @(negedge clk); hs_i = 1'b1; de_i = 1'b0; data_i = 24'd0;
            end
            for (int c = 0; c < (extra ? 71 : W); c++) begin
                @(negedge clk); hs_i = 1'b0; de_i = 1'b1;
                data_i = pix(c, r, bx0, bx1, by0, by1, extra);
            end
            repeat (2) begin
                @(negedge clk); de_i = 1'b0; data_i = 24'd0;
            end
        end
    endtask

    int          p0, p1;
    logic        fdf0, fdf1, vsof;
    logic [43:0] r0, r1;
    logic        v0, v1;

    // Vertical sync held high 3 cycles; records the state one cycle after
    // vs_i is first sampled high, and counts frame_done pulses.
    task automatic vsync();
        @(negedge clk); vs_i = 1'b1; hs_i = 1'b0; de_i = 1'b0; data_i = 24'd0;
        p0 = 0; p1 = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) begin
                fdf0 = fd0; fdf1 = fd1; vsof = vs_o0;
                r0 = {x1_0, y1_0, x2_0, y2_0}; v0 = rv0;
                r1 = {x1_1, y1_1, x2_1, y2_1}; v1 = rv1;
            end
            if (fd0) p0++;
            if (fd1) p1++;
            if (i == 2) vs_i = 1'b0;
        end
    endtask

    function automatic logic [43:0] box(input int a, input int b, input int c, input int d);
        return {11'(a), 11'(b), 11'(c), 11'(d)};
    endfunction

    initial begin
        // reset values
        repeat (3) @(negedge clk);
        check("rst_rect0", {20'd0, x1_0, y1_0, x2_0, y2_0}, 64'd0);
        check("rst_flags0", {59'd0, rv0, fd0, st0, vs_o0, de_o0}, 64'd0);
        check("rst_data0", {40'd0, data_o0}, 64'd0);
        check("rst_rect1", {19'd0, rv1, x1_1, y1_1, x2_1, y2_1}, 64'd0);
        rst_n = 1'b1;

        // Block present before the first sync: only arms, no publish.
        lines(10, 19, 5, 14, 1'b0, H);
        vsync();
        check("arm_pulses", 64'(p0), 64'd0);
        check("arm_state", {63'd0, st0}, 64'd1);

        // Full frame with a 10x10 block.
        lines(10, 19, 5, 14, 1'b0, H);
        vsync();
        check("blk_fd_first", {63'd0, fdf0}, 64'd1);
        check("blk_vso_same_edge", {63'd0, vsof}, 64'd1);
        check("blk_pulses", 64'(p0), 64'd1);
        check("blk_rect0", {20'd0, r0}, {20'd0, box(10, 5, 19, 14)});
        check("blk_valid0", {63'd0, v0}, 64'd1);
        check("blk_rect1", {20'd0, r1}, {20'd0, box(10, 5, 19, 14)});

        // 10 foreground pixels: below MIN_PIX for dut0 only.
        lines(30, 39, 20, 20, 1'b0, H);
        vsync();
        check("few_fd0", {63'd0, fdf0}, 64'd1);
        check("few_pulses0", 64'(p0), 64'd1);
        check("few_valid0", {63'd0, v0}, 64'd0);
        check("few_rect0_held", {20'd0, r0}, {20'd0, box(10, 5, 19, 14)});
        check("few_valid1", {63'd0, v1}, 64'd1);
        check("few_rect1", {20'd0, r1}, {20'd0, box(30, 20, 39, 20)});
        check("few_pulses1", 64'(p1), 64'd1);

        // Single corner pixel; red beyond IMG_W and beyond IMG_H is ignored.
        lines(W - 1, W - 1, H - 1, H - 1, 1'b1, H + 1);
        vsync();
        check("corner_rect1", {20'd0, r1}, {20'd0, box(W - 1, H - 1, W - 1, H - 1)});
        check("corner_valid1", {63'd0, v1}, 64'd1);
        check("corner_valid0", {63'd0, v0}, 64'd0);
        check("corner_rect0_held", {20'd0, r0}, {20'd0, box(10, 5, 19, 14)});

        // Reset in the middle of accumulation.
        lines(10, 19, 5, 14, 1'b0, 10);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_rect0", {20'd0, x1_0, y1_0, x2_0, y2_0}, 64'd0);
        check("mid_rst_rect1", {20'd0, x1_1, y1_1, x2_1, y2_1}, 64'd0);
        check("mid_rst_flags", {60'd0, rv1, fd0, st0, st1}, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        lines(10, 19, 5, 14, 1'b0, H);
        vsync();
        check("post_rst_arm", 64'(p0 + p1), 64'd0);
        lines(40, 49, 30, 40, 1'b0, H);
        vsync();
        check("post_rst_pulses", 64'(p0), 64'd1);
        check("post_rst_rect0", {20'd0, r0}, {20'd0, box(40, 30, 49, 40)});
        check("post_rst_valid0", {63'd0, v0}, 64'd1);

        // Random sync/data: outputs are inputs delayed by exactly one cycle.
        @(negedge clk);
        pt_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            vs_i   = 1'($urandom_range(0, 1));
            hs_i   = 1'($urandom_range(0, 1));
            de_i   = 1'($urandom_range(0, 1));
            data_i = 24'($urandom_range(0, 32'hFFFFFF));
        end
        @(negedge clk);
        pt_en = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #5000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/img_bbox_detect.md
# img_bbox_detect

Colour-threshold bounding-box detector sitting directly upstream of the rectangle-overlay stage in the img_box pipeline. Classifies each active pixel as foreground when every 8-bit channel lies inside a programmable window. Tracks the min/max column and row of foreground pixels over one frame and publishes the box at the next vertical sync. Video passes through with one register stage so timing matches the overlay stage's input.

## Interface

- IMG_W, 640, active pixels per line; row advance at col_cnt == IMG_W-1 with de_i.
- IMG_H, 480, active lines per frame; pixels with row_cnt >= IMG_H are ignored for statistics.
- MIN_PIX, 16, minimum foreground pixel count for a frame's box to be declared valid.

- clk  in  1  pixel clock.
- rst_n  in  1  reset, asynchronous, active-low.
- vs_i  in  1  vertical sync, active-high; high level clears row counter.
- hs_i  in  1  horizontal sync, active-high; high level clears column counter.
- de_i  in  1  active-pixel qualifier.
- data_i  in  24  pixel {R[23:16], G[15:8], B[7:0]}.
- thr_lo  in  24  per-channel inclusive lower bound, same packing.
- thr_hi  in  24  per-channel inclusive upper bound, same packing.
- vs_o, hs_o, de_o  out  1 each  vs_i/hs_i/de_i delayed one cycle.
- data_o  out  24  data_i delayed one cycle, unmodified.
- rect_x1, rect_y1, rect_x2, rect_y2  out  11 each  last published box (min col, min row, max col, max row).
- rect_valid  out  1  last published box met MIN_PIX.
- frame_done  out  1  one-cycle pulse when box outputs update.

## Operation

- Counters: col_cnt (11b) cleared when hs_i=1, else +1 when de_i=1. row_cnt (11b) cleared when vs_i=1, else +1 when de_i=1 && col_cnt==IMG_W-1.
- Foreground: fg = de_i && !vs_i && col_cnt<IMG_W && row_cnt<IMG_H && thr_lo[k] <= data_i[k] <= thr_hi[k] for all three channels (unsigned, inclusive). If lo>hi on any channel, no pixel matches.
- Accumulators: min_x and min_y initialise to 11'h7FF, max_x and max_y to 0, fg_cnt (21b) to 0. On fg: min/max update with the current col_cnt/row_cnt, and fg_cnt increments, saturating at all-ones.
- vs_rise = vs_i && !vs_d, where vs_d is vs_i registered (reset 0).
- FSM, 2 states:
  - IDLE (reset state): accumulators are held at their init values. On vs_rise, go to ACTIVE with no publish, so a partial first frame is never reported.
  - ACTIVE: accumulate. On vs_rise, publish and re-initialise the accumulators in the same edge, then stay in ACTIVE.
- Publish:
  - If fg_cnt >= MIN_PIX: rect_* <= min_x, min_y, max_x, max_y and rect_valid <= 1.
  - Otherwise: rect_* hold their previous values and rect_valid <= 0.
  - In both cases frame_done <= 1 for one cycle.
- rect_* are stable for an entire frame between publishes. The downstream overlay samples them freely.
- A foreground pixel in the same cycle as vs_rise is excluded, because fg requires !vs_i.

## Timing

- Pass-through latency is exactly 1 cycle for vs/hs/de/data.
- Box latency: rect_*, rect_valid and frame_done change on the clock edge following the cycle where vs_i first samples high. That is the same edge on which vs_o rises.
- Reset values: all outputs 0, FSM in IDLE, vs_d = 0, accumulators at their init values.
- Reset asserted mid-frame: everything returns to reset values immediately. The next vs_rise only arms the FSM; the first publish comes one frame later.
- vs_i held high for multiple cycles publishes once. A single-pixel box gives x1==x2 and y1==y2.

## Test plan

- 640x480 frame, thr_lo=24'h C00000, thr_hi=24'h FF3F3F, red (FF0000) block at cols 100..199, rows 50..149, background 000000. Required at the following vs_rise+1: rect=(100,50,199,149), rect_valid=1, frame_done high for 1 cycle.
- First vs_rise after reset, with the red block present before it. Required: no frame_done. Second vs_rise publishes the box of the full frame only.
- Frame with 10 red pixels and MIN_PIX=16, following a valid frame. Required: rect_valid=0, rect_* unchanged from the previous frame, frame_done pulses.
- Single red pixel at (639,479) with MIN_PIX=1. Required: rect=(639,479,639,479), valid=1. Red pixel driven at col 700 (de beyond IMG_W) is ignored.
- Reset pulse mid-frame during accumulation. Required: all outputs 0 immediately; the first publish occurs at the second vs_rise after release.
- Random data/sync stimulus. Required: vs_o/hs_o/de_o/data_o equal the inputs delayed exactly 1 cycle on every cycle.
